alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Sequential execute stage of the RV32I core: accepts one decoded ALU operation with two 32-bit operands over a valid/ready handshake, evaluates it, and presents a registered result with its destination register index to writeback over a second valid/ready handshake. Logic ops (AND/OR/XOR) use the existing single-cycle function units; shifts run on an iterative 1-bit-per-cycle shifter unless the fast shifter is compiled in. The block sits between the decode/operand-fetch stage (upstream) and register-file writeback (downstream).

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  unit can accept an op this cycle.
- in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10–15 reserved.
- in_a  input  32  operand rs1.
- in_b  input  32  operand rs2/imm; shifts use in_b[4:0] as shamt.
- in_rd  input  5  destination register index.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  registered result.
- out_rd  output  5  registered destination index.
- out_illegal  output  1  reserved opcode flag, qualified by out_valid.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Never asserted in SHIFT.
- Accept = in_valid & in_ready. On accept: latch op, operands, rd.
  - Non-shift op, or shift with shamt==0: result computed and registered; next state DONE.
  - Shift with shamt>0: load a into shift register, load shamt into down-counter; next state SHIFT.
- SHIFT: each cycle shift one bit (SLL: left, zero fill; SRL: right, zero fill; SRA: right, replicate bit 31), decrement counter; when counter reaches 1 this cycle, next state DONE with final value registered.
- DONE: out_valid=1. If out_ready & no accept → IDLE. If out_ready & accept → back-to-back: new op latched, state per the rules above. If !out_ready: hold out_result/out_rd/out_illegal stable.
- Arithmetic: ADD/SUB modulo 2^32, no overflow flag. SLT signed compare, SLTU unsigned; result 0 or 1 zero-extended.
- Reserved opcode: out_result=0, out_illegal=1, 1-cycle latency.
- in_rd==0 passes through unchanged; writeback discards x0.

## Timing
- Reset (async assert, sync release to clk): state IDLE, out_valid=0, out_result=0, out_rd=0, out_illegal=0, in_ready=1 after release.
- Non-shift latency: accept at edge N → out_valid high after edge N (visible cycle N+1).
- Iterative shift latency: 1 + shamt cycles from accept to out_valid (shamt=31 → 32 cycles).
- Throughput: one op per cycle for non-shift ops with out_ready held high.
- Reset asserted mid-SHIFT or in DONE: op dropped, outputs to reset values immediately.
- in_* inputs ignored while in_ready=0; upstream holds them stable.

## Configuration
- SHIFT_FAST_EN defined: shifts use a single-cycle barrel shifter; SHIFT state unreachable; all ops 1-cycle latency and in_ready depends only on DONE/out_ready.
- SHIFT_FAST_EN undefined: iterative shifter and SHIFT state as above. Results identical in both builds; only latency differs.

## Test plan
- AND a=0xFFFF0000 b=0x0F0F0F0F, then a=0xAAAAAAAA b=0x55555555 back-to-back, out_ready=1 → results 0x0F0F0000 then 0x00000000 on consecutive cycles, in_ready stays 1.
- SLL a=0x00000001 b=31 → out_result 0x80000000 after 32 cycles (1 cycle with SHIFT_FAST_EN); in_ready=0 throughout SHIFT.
- SRA a=0x80000000 b=4 → 0xF8000000; SRL same operands → 0x08000000; shamt=0 → a returned in 1 cycle.
- SLT a=0xFFFFFFFF b=0x00000001 → 1; SLTU same → 0; SUB a=0 b=1 → 0xFFFFFFFF; op=12 → result 0, out_illegal=1.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 → out_result/out_rd stable, in_ready=0, no op accepted; release → next op accepted same cycle.
- Assert rst_n=0 mid-shift (SLL b=20, cycle 10) → out_valid=0, out_result=0 immediately; after release a new ADD 3+4 yields 7 with out_rd as driven.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between operand fetch, the ALU execute stage and writeback.
// Latency: none; wires only.
// Backpressure: in_ready gates the upstream op, out_ready gates the result.
interface alu_exec_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  // Upstream producer plus downstream consumer side (drives ops, sinks results)
  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  // Execute unit side
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I ALU execute stage: one op in, one registered result + rd out (SHIFT_FAST_EN selects a barrel shifter).
// Latency: 1 cycle for non-shift ops; iterative shifts take 1+shamt cycles (1 cycle with SHIFT_FAST_EN).
// Backpressure: in_ready only in IDLE or in DONE with out_ready; result held stable while out_ready is low.
module alu_exec_unit (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  io
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;   // doubles as the shift register while in SHIFT
  logic [4:0]  rd_q, rd_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  cnt_q, cnt_d;         // remaining single-bit shift steps
  logic [1:0]  shkind_q, shkind_d;   // in_op[1:0]: 01 SLL, 10 SRL, 11 SRA

  logic        accept;
  logic        is_shift;
  logic        start_iter;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        alu_ill;
  logic [31:0] shift_step;

  assign io.in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && io.out_ready);
  assign accept         = io.in_valid && io.in_ready;
  assign io.out_valid   = (state_q == ST_DONE);
  assign io.out_result  = result_q;
  assign io.out_rd      = rd_q;
  assign io.out_illegal = illegal_q;

  assign shamt    = io.in_b[4:0];
  assign is_shift = (io.in_op == OP_SLL) || (io.in_op == OP_SRL) || (io.in_op == OP_SRA);

`ifdef SHIFT_FAST_EN
  assign start_iter = 1'b0;
`else
  // A zero shift amount is finished on accept, so it never enters SHIFT
  assign start_iter = accept && is_shift && (shamt != 5'd0);
`endif

  // Single-cycle function units evaluated on the incoming operands
  always_comb begin
    alu_res = 32'd0;
    alu_ill = 1'b0;
    case (io.in_op)
      OP_ADD:  alu_res = io.in_a + io.in_b;
      OP_SUB:  alu_res = io.in_a - io.in_b;
      OP_AND:  alu_res = io.in_a & io.in_b;
      OP_OR:   alu_res = io.in_a | io.in_b;
      OP_XOR:  alu_res = io.in_a ^ io.in_b;
`ifdef SHIFT_FAST_EN
      OP_SLL:  alu_res = io.in_a << shamt;
      OP_SRL:  alu_res = io.in_a >> shamt;
      OP_SRA:  alu_res = 32'($signed(io.in_a) >>> shamt);
`else
      // Only reached with shamt==0; nonzero amounts go through the iterative path
      OP_SLL, OP_SRL, OP_SRA: alu_res = io.in_a;
`endif
      OP_SLT:  alu_res = {31'd0, ($signed(io.in_a) < $signed(io.in_b))};
      OP_SLTU: alu_res = {31'd0, (io.in_a < io.in_b)};
      default: begin
        alu_res = 32'd0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // One-bit shift step applied to the shift register each SHIFT cycle
  always_comb begin
    case (shkind_q)
      2'b01:   shift_step = {result_q[30:0], 1'b0};
      2'b10:   shift_step = {1'b0, result_q[31:1]};
      default: shift_step = {result_q[31], result_q[31:1]};
    endcase
  end

  // Next-state logic: FSM progression, then an accepted op overrides (covers back-to-back from DONE)
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    shkind_d  = shkind_q;

    case (state_q)
      ST_SHIFT: begin
        result_d = shift_step;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io.out_ready && !accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_IDLE;
      end
    endcase

    if (accept) begin
      rd_d      = io.in_rd;
      illegal_d = alu_ill;
      shkind_d  = io.in_op[1:0];
      if (start_iter) begin
        result_d = io.in_a;
        cnt_d    = shamt;
        state_d  = ST_SHIFT;
      end else begin
        result_d = alu_res;
        cnt_d    = 5'd0;
        state_d  = ST_DONE;
      end
    end
  end

  // State and output registers; reset drops any in-flight op immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= 32'd0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      cnt_q     <= 5'd0;
      shkind_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      shkind_q  <= shkind_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, backpressure and reset.
// Latency: expected shift latency follows SHIFT_FAST_EN (1 cycle) or 1+shamt.
// Backpressure: holds out_ready low in DONE and checks that the result and in_ready stay put.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected accept-to-valid latency of a shift by n
  function automatic int shlat(input int n);
`ifdef SHIFT_FAST_EN
    return 1;
`else
    return (n == 0) ? 1 : 1 + n;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE with out_ready high, wait for the result, check it, drain to IDLE
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] er,
                       input logic eill, input int elat);
    int   lat;
    logic rdy_seen;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat          = 1;
    rdy_seen     = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".res"}, bus.out_result, er);
    chk({tag, ".rd"}, {27'd0, bus.out_rd}, {27'd0, rd});
    chk({tag, ".ill"}, {31'd0, bus.out_illegal}, {31'd0, eill});
    chk({tag, ".busy_rdy"}, {31'd0, rdy_seen}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.res", bus.out_result, 32'd0);
    chk("rst.rd", {27'd0, bus.out_rd}, 32'd0);
    chk("rst.ill", {31'd0, bus.out_illegal}, 32'd0);
    chk("rst.rdy", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back AND with out_ready high
    bus.in_valid = 1'b1; bus.in_op = 4'd2; bus.in_a = 32'hFFFF0000; bus.in_b = 32'h0F0F0F0F; bus.in_rd = 5'd3;
    @(negedge clk);
    chk("and1.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("and1.res", bus.out_result, 32'h0F0F0000);
    chk("and1.rdy", {31'd0, bus.in_ready}, 32'd1);
    bus.in_a = 32'hAAAAAAAA; bus.in_b = 32'h55555555; bus.in_rd = 5'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("and2.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("and2.res", bus.out_result, 32'h00000000);
    chk("and2.rd", {27'd0, bus.out_rd}, 32'd4);
    @(negedge clk);
    chk("and2.idle", {31'd0, bus.out_valid}, 32'd0);

    // Shifts, compares, arithmetic, reserved opcode, x0 destination
    do_op("sll31", 4'd5, 32'h00000001, 32'd31, 5'd5, 32'h80000000, 1'b0, shlat(31));
    do_op("sra4",  4'd7, 32'h80000000, 32'd4,  5'd6, 32'hF8000000, 1'b0, shlat(4));
    do_op("srl4",  4'd6, 32'h80000000, 32'd4,  5'd7, 32'h08000000, 1'b0, shlat(4));
    do_op("sll0",  4'd5, 32'h12345678, 32'd0,  5'd8, 32'h12345678, 1'b0, 1);
    do_op("sra_hi",4'd7, 32'hF0000000, 32'h00000024, 5'd9, 32'hFF000000, 1'b0, shlat(4));
    do_op("slt",   4'd8, 32'hFFFFFFFF, 32'h00000001, 5'd10, 32'd1, 1'b0, 1);
    do_op("sltu",  4'd9, 32'hFFFFFFFF, 32'h00000001, 5'd11, 32'd0, 1'b0, 1);
    do_op("sub",   4'd1, 32'h00000000, 32'h00000001, 5'd12, 32'hFFFFFFFF, 1'b0, 1);
    do_op("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000002, 5'd13, 32'h00000001, 1'b0, 1);
    do_op("or",    4'd3, 32'hF0F00000, 32'h0000F0F0, 5'd14, 32'hF0F0F0F0, 1'b0, 1);
    do_op("xor",   4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 1'b0, 1);
    do_op("rsv12", 4'd12, 32'h12345678, 32'h9ABCDEF0, 5'd15, 32'd0, 1'b1, 1);

    // Backpressure: result held, nothing accepted, then immediate accept on release
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'd5; bus.in_b = 32'd6; bus.in_rd = 5'd9;
    @(negedge clk);
    bus.in_op = 4'd4; bus.in_a = 32'hFF00FF00; bus.in_b = 32'h0FF00FF0; bus.in_rd = 5'd21;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp.res", bus.out_result, 32'd11);
      chk("bp.rd", {27'd0, bus.out_rd}, 32'd9);
      chk("bp.rdy", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.next_res", bus.out_result, 32'hF0F0F0F0);
    chk("bp.next_rd", {27'd0, bus.out_rd}, 32'd21);
    @(negedge clk);

    // Reset in the middle of an iterative shift
    bus.in_valid = 1'b1; bus.in_op = 4'd5; bus.in_a = 32'h00000001; bus.in_b = 32'd20; bus.in_rd = 5'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst.res", bus.out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst_add", 4'd0, 32'd3, 32'd4, 5'd17, 32'd7, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
